imem_loader: RTL

//  Writer side of the instruction memory: accepts instruction words from the host over a

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_beat_packer.sv | 47 ++++
 rtl/imem_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and default widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 64;
  localparam int unsigned LOADER_HOST_WIDTH = 32;
  localparam int unsigned LOADER_ADDR_WIDTH = 8;

  typedef logic [INSTRUCTION_WIDTH-1:0] instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    DONE
  } imem_loader_state_t;

  // Host beats needed to cover one instruction word (rounded up).
  function automatic int unsigned beats_per_word(input int unsigned inst_w, input int unsigned host_w);
    return (inst_w + host_w - 1) / host_w;
  endfunction

endpackage

// File: rtl/imem_beat_packer.sv
// Collects host beats LSB-first into one instruction word; flags the beat that completes it.
module imem_beat_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned INST_WIDTH = INSTRUCTION_WIDTH,
  parameter int unsigned HOST_WIDTH = LOADER_HOST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [HOST_WIDTH-1:0] beat_data,
  output logic [INST_WIDTH-1:0] word_c,
  output logic                  word_full_c
);

  localparam int unsigned BEATS  = beats_per_word(INST_WIDTH, HOST_WIDTH);
  localparam int unsigned FILL_W = BEATS * HOST_WIDTH;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  beat_cnt_q;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_c;

  // Merge the beat being accepted so the completed word is visible in the same cycle.
  always_comb begin
    fill_c = fill_q;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (accept && (beat_cnt_q == CNT_W'(b))) begin
        fill_c[b*HOST_WIDTH +: HOST_WIDTH] = beat_data;
      end
    end
    word_c      = fill_c[INST_WIDTH-1:0];
    word_full_c = accept && (beat_cnt_q == CNT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt_q <= '0;
      fill_q     <= '0;
    end else if (accept) begin
      fill_q     <= fill_c;
      beat_cnt_q <= word_full_c ? '0 : CNT_W'(beat_cnt_q + 1'b1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Host-to-IMEM loader: packs host beats into instruction words and writes them from address 0.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned INST_WIDTH      = INSTRUCTION_WIDTH,
  parameter int unsigned HOST_WIDTH      = LOADER_HOST_WIDTH,
  parameter int unsigned IMEM_ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic [IMEM_ADDR_WIDTH-1:0] load_len,
  input  logic                       load_abort,
  input  logic                       host_valid,
  input  logic [HOST_WIDTH-1:0]      host_data,
  output logic                       host_ready,
  output logic                       imem_wr_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [INST_WIDTH-1:0]      imem_wr_data,
  output logic [IMEM_ADDR_WIDTH-1:0] instruction_count,
  output logic                       load_busy,
  output logic                       load_done
);

  imem_loader_state_t state_q, state_d;

  logic [IMEM_ADDR_WIDTH-1:0] len_q;
  logic [INST_WIDTH-1:0]      word_c;
  logic                       word_full_c;
  logic                       accept_c;
  logic                       start_ok_c;
  logic                       last_write_c;

  assign accept_c = host_valid && host_ready;

  imem_beat_packer #(
    .INST_WIDTH (INST_WIDTH),
    .HOST_WIDTH (HOST_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok_c || load_abort),
    .accept      (accept_c),
    .beat_data   (host_data),
    .word_c      (word_c),
    .word_full_c (word_full_c)
  );

  // Next-state logic; abort overrides every transition, including a same-cycle start.
  always_comb begin
    state_d      = state_q;
    start_ok_c   = load_start && ((state_q == IDLE) || (state_q == DONE));
    last_write_c = (IMEM_ADDR_WIDTH'(instruction_count + 1'b1) == len_q);
    case (state_q)
      IDLE, DONE: begin
        if (start_ok_c) begin
          state_d = (load_len == '0) ? DONE : ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (word_full_c) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = last_write_c ? DONE : ASSEMBLE;
      end
      default: state_d = IDLE;
    endcase
    if (load_abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      host_ready <= 1'b0;
      imem_wr_en <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      host_ready <= (state_d == ASSEMBLE);
      imem_wr_en <= (state_d == WRITE);
      load_busy  <= (state_d == ASSEMBLE) || (state_d == WRITE);
      load_done  <= (state_d == DONE);
    end
  end

  // Length latch, completed-write counter and the held IMEM write registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q             <= '0;
      instruction_count <= '0;
      imem_wr_addr      <= '0;
      imem_wr_data      <= '0;
    end else begin
      if (start_ok_c && !load_abort) begin
        len_q             <= load_len;
        instruction_count <= '0;
      end else if ((state_q == WRITE) && !load_abort) begin
        instruction_count <= IMEM_ADDR_WIDTH'(instruction_count + 1'b1);
      end
      if (state_d == WRITE) begin
        imem_wr_addr <= instruction_count;
        imem_wr_data <= word_c;
      end
    end
  end

endmodule
